partition_sweep_ctrl: RTL

Sequencer that drives an exhaustive input sweep through one combinational partition (exact and approximate versions in parallel) and accumulates error metrics in hardware. It replaces per-vector display-and-diff checking of partition outputs: the controller walks every input vector, compares the exact and approximate responses, and reports the mismatch count and total bit-flip count. It sits between the partition pair and the evaluation flow's result-collection logic.

---
 rtl/partition_sweep_ctrl.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/partition_sweep_ctrl.sv
// Exhaustive input sweep of one partition pair (exact vs approximate) with
// hardware error accumulation. Define PARTITION_SWEEP_WCE_EN to track worst-case error.
module partition_sweep_ctrl #(
  parameter int IN_W  = 7,
  parameter int OUT_W = 4,
  parameter int LAT   = 0
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               start,
  input  logic                               abort,
  output logic [IN_W-1:0]                    pi,
  input  logic [OUT_W-1:0]                   exact_po,
  input  logic [OUT_W-1:0]                   approx_po,
  output logic                               busy,
  output logic                               done,
  output logic                               result_valid,
  output logic [IN_W:0]                      err_count,
  output logic [IN_W+$clog2(OUT_W+1)-1:0]    bit_err_total,
  output logic [OUT_W-1:0]                   wce,
  output logic [IN_W-1:0]                    wce_vec
);

  // state  | meaning
  // IDLE   | waiting for start; results of the last sweep held
  // SWEEP  | issuing vectors 0 .. 2^IN_W-1 on pi
  // DRAIN  | waiting LAT cycles for the last responses
  // DONE   | one-cycle completion pulse
  typedef enum logic [1:0] {S_IDLE, S_SWEEP, S_DRAIN, S_DONE} state_t;

  localparam int             BW         = IN_W + $clog2(OUT_W + 1);
  localparam logic [IN_W-1:0] PI_MAX     = '1;
  localparam logic [1:0]     DRAIN_LOAD = 2'((LAT > 0) ? LAT - 1 : 0);

  state_t          state, state_next;
  logic [1:0]      drain_cnt;
  logic            clear_acc;
  logic            issue_vld;
  logic            acc_vld;
  logic [IN_W-1:0] acc_vec;
  logic            last_vec;

  assign last_vec = (pi == PI_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start && !abort) state_next = S_SWEEP;
      S_SWEEP: begin
        if (abort)         state_next = S_IDLE;
        else if (last_vec) state_next = (LAT > 0) ? S_DRAIN : S_DONE;
      end
      S_DRAIN: begin
        if (abort)                state_next = S_IDLE;
        else if (drain_cnt == '0) state_next = S_DONE;
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    clear_acc = 1'b0;
    issue_vld = 1'b0;
    case (state)
      S_IDLE:  clear_acc = start && !abort;
      S_SWEEP: begin
        busy      = 1'b1;
        issue_vld = !abort;
      end
      S_DRAIN: busy = 1'b1;
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pi        <= '0;
      drain_cnt <= '0;
    end else begin
      if (clear_acc)
        pi <= '0;
      else if (issue_vld && !last_vec)
        pi <= pi + 1'b1;

      if (issue_vld && last_vec)
        drain_cnt <= DRAIN_LOAD;
      else if (state == S_DRAIN && drain_cnt != '0)
        drain_cnt <= drain_cnt - 1'b1;
    end
  end

  // Valid/vector pipe aligns each issued vector with its response.
  generate
    if (LAT == 0) begin : g_nolat
      assign acc_vld = issue_vld;
      assign acc_vec = pi;
    end else begin : g_lat
      logic [LAT-1:0]  vld_q;
      logic [IN_W-1:0] vec_q [LAT];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vld_q <= '0;
          for (int i = 0; i < LAT; i++) vec_q[i] <= '0;
        end else begin
          vld_q[0] <= issue_vld;
          vec_q[0] <= pi;
          for (int i = 1; i < LAT; i++) begin
            vld_q[i] <= vld_q[i-1];
            vec_q[i] <= vec_q[i-1];
          end
          if (abort) vld_q <= '0;
        end
      end

      assign acc_vld = vld_q[LAT-1] && !abort;
      assign acc_vec = vec_q[LAT-1];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count     <= '0;
      bit_err_total <= '0;
      result_valid  <= 1'b0;
    end else begin
      if (clear_acc) begin
        err_count     <= '0;
        bit_err_total <= '0;
      end else if (acc_vld) begin
        if (exact_po != approx_po) err_count <= err_count + (IN_W+1)'(1);
        bit_err_total <= bit_err_total + BW'($countones(exact_po ^ approx_po));
      end

      if (clear_acc || (abort && state != S_DONE))
        result_valid <= 1'b0;
      else if (state_next == S_DONE)
        result_valid <= 1'b1;
    end
  end

`ifdef PARTITION_SWEEP_WCE_EN
  logic [OUT_W-1:0] abs_err;

  always_comb begin
    abs_err = (exact_po >= approx_po) ? (exact_po - approx_po) : (approx_po - exact_po);
  end

  // Strict compare keeps the first vector that reached the maximum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wce     <= '0;
      wce_vec <= '0;
    end else if (clear_acc) begin
      wce     <= '0;
      wce_vec <= '0;
    end else if (acc_vld && abs_err > wce) begin
      wce     <= abs_err;
      wce_vec <= acc_vec;
    end
  end
`else
  logic unused_acc_vec;
  assign unused_acc_vec = ^acc_vec;
  assign wce            = '0;
  assign wce_vec        = '0;
`endif

endmodule
